// File: rtl/sd_disp_arb_if.sv
// Display-arbiter bus: three requesters' frames and requests in,
// selected owner and latched frame out to the 595 scan controller.
interface sd_disp_arb_if;
    logic [2:0]  req;
    logic [2:0]  upd;
    logic [23:0] data0;
    logic [23:0] data1;
    logic [23:0] data2;
    logic [5:0]  tw0;
    logic [5:0]  tw1;
    logic [5:0]  tw2;
    logic [5:0]  dp0;
    logic [5:0]  dp1;
    logic [5:0]  dp2;
    logic [2:0]  gnt;
    logic        valid_sd;
    logic [23:0] data_sd;
    logic [5:0]  twinkle;
    logic [5:0]  dp;

    // Requester side drives requests and frames, reads grant and frame.
    modport master (
        output req, upd, data0, data1, data2, tw0, tw1, tw2, dp0, dp1, dp2,
        input  gnt, valid_sd, data_sd, twinkle, dp
    );

    // Arbiter side.
    modport slave (
        input  req, upd, data0, data1, data2, tw0, tw1, tw2, dp0, dp1, dp2,
        output gnt, valid_sd, data_sd, twinkle, dp
    );
endinterface

// File: rtl/sd_disp_arb.sv
// Seven-segment display arbiter: picks one of three requesters (2 > 1 > 0),
// latches its frame, pulses valid_sd on every new frame, holds ownership for
// a minimum time before preemption, re-issues the frame periodically and
// blanks the display when nobody is requesting.
module sd_disp_arb #(
    parameter int MIN_HOLD = 50_000_000,
    parameter int REFRESH  = 1_000_000,
    parameter int CNT_W    = 26
) (
    input  logic          sysclk,
    input  logic          rst,
    sd_disp_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX    = CNT_W'(MIN_HOLD - 1);
    localparam logic [CNT_W-1:0] REFRESH_MAX = CNT_W'(REFRESH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [23:0]      BLANK_DIGITS = 24'hFFFFFF;

    state_t           state_q;
    logic [2:0]       gnt_q;
    logic             valid_q;
    logic [23:0]      data_q;
    logic [5:0]       tw_q;
    logic [5:0]       dp_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic [CNT_W-1:0] refresh_cnt_q;

    logic [2:0]       pick;
    logic             higher_req;
    logic             owner_req;
    logic             owner_upd;
    logic             refresh_wrap;
    logic             hold_done;
    logic [23:0]      sel_data;
    logic [5:0]       sel_tw;
    logic [5:0]       sel_dp;

    // Highest-priority active request, one-hot.
    always_comb begin
        pick = 3'b000;
        if (bus.req[2])      pick = 3'b100;
        else if (bus.req[1]) pick = 3'b010;
        else if (bus.req[0]) pick = 3'b001;
    end

    // Is anyone above the current owner asking for the display?
    always_comb begin
        higher_req = 1'b0;
        case (gnt_q)
            3'b001:  higher_req = bus.req[2] | bus.req[1];
            3'b010:  higher_req = bus.req[2];
            default: higher_req = 1'b0;
        endcase
    end

    // Owner's live frame inputs; the grant is already stable while they are latched.
    always_comb begin
        sel_data = bus.data0;
        sel_tw   = bus.tw0;
        sel_dp   = bus.dp0;
        case (gnt_q)
            3'b010: begin
                sel_data = bus.data1;
                sel_tw   = bus.tw1;
                sel_dp   = bus.dp1;
            end
            3'b100: begin
                sel_data = bus.data2;
                sel_tw   = bus.tw2;
                sel_dp   = bus.dp2;
            end
            default: begin
                sel_data = bus.data0;
                sel_tw   = bus.tw0;
                sel_dp   = bus.dp0;
            end
        endcase
    end

    // Saturating hold count and per-cycle event decode.
    always_comb begin
        owner_req    = |(bus.req & gnt_q);
        owner_upd    = |(bus.upd & gnt_q);
        refresh_wrap = (refresh_cnt_q == REFRESH_MAX);
        hold_done    = (hold_cnt_q == HOLD_MAX);
        hold_cnt_d   = hold_done ? hold_cnt_q : hold_cnt_q + CNT_ONE;
    end

    // Ownership state machine with registered grant and frame outputs.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            gnt_q         <= 3'b000;
            valid_q       <= 1'b0;
            data_q        <= BLANK_DIGITS;
            tw_q          <= 6'b000000;
            dp_q          <= 6'b000000;
            hold_cnt_q    <= CNT_ZERO;
            refresh_cnt_q <= CNT_ZERO;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state_q       <= ST_LOAD;
                        gnt_q         <= pick;
                        hold_cnt_q    <= CNT_ZERO;
                        refresh_cnt_q <= CNT_ZERO;
                    end
                end
                ST_LOAD: begin
                    data_q  <= sel_data;
                    tw_q    <= sel_tw;
                    dp_q    <= sel_dp;
                    valid_q <= 1'b1;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!owner_req && (|bus.req)) begin
                        // Owner released: hand over immediately, no hold needed.
                        state_q       <= ST_LOAD;
                        gnt_q         <= pick;
                        hold_cnt_q    <= CNT_ZERO;
                        refresh_cnt_q <= CNT_ZERO;
                    end else if (!owner_req) begin
                        // Nobody left: blank the display once.
                        state_q       <= ST_IDLE;
                        gnt_q         <= 3'b000;
                        data_q        <= BLANK_DIGITS;
                        tw_q          <= 6'b000000;
                        dp_q          <= 6'b000000;
                        valid_q       <= 1'b1;
                        hold_cnt_q    <= CNT_ZERO;
                        refresh_cnt_q <= CNT_ZERO;
                    end else if (higher_req && hold_done) begin
                        state_q       <= ST_LOAD;
                        gnt_q         <= pick;
                        hold_cnt_q    <= CNT_ZERO;
                        refresh_cnt_q <= CNT_ZERO;
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                        // Owner update and periodic re-issue share one relatch/pulse.
                        if (owner_upd || refresh_wrap) begin
                            data_q        <= sel_data;
                            tw_q          <= sel_tw;
                            dp_q          <= sel_dp;
                            valid_q       <= 1'b1;
                            refresh_cnt_q <= CNT_ZERO;
                        end else begin
                            refresh_cnt_q <= refresh_cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 3'b000;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.valid_sd = valid_q;
    assign bus.data_sd  = data_q;
    assign bus.twinkle  = tw_q;
    assign bus.dp       = dp_q;

endmodule

// File: tb/tb_sd_disp_arb.sv
// Directed bench for sd_disp_arb with MIN_HOLD=8, REFRESH=16.
module tb_sd_disp_arb;

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    sd_disp_arb_if u_if ();

    sd_disp_arb #(
        .MIN_HOLD (8),
        .REFRESH  (16),
        .CNT_W    (26)
    ) u_dut (
        .sysclk (sysclk),
        .rst    (rst),
        .bus    (u_if)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle past it.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Compare every output against one expected frame.
    task automatic check_out(input string tag, input logic [2:0] g, input logic v,
                             input logic [23:0] d, input logic [5:0] t, input logic [5:0] p);
        check({tag, ".gnt"},     32'(u_if.gnt),      32'(g));
        check({tag, ".valid"},   32'(u_if.valid_sd), 32'(v));
        check({tag, ".data_sd"}, 32'(u_if.data_sd),  32'(d));
        check({tag, ".twinkle"}, 32'(u_if.twinkle),  32'(t));
        check({tag, ".dp"},      32'(u_if.dp),       32'(p));
    endtask

    initial begin
        u_if.req = 3'b000;  u_if.upd = 3'b000;
        u_if.data0 = 24'h123456; u_if.tw0 = 6'b000000; u_if.dp0 = 6'b000100;
        u_if.data1 = 24'h987654; u_if.tw1 = 6'b110000; u_if.dp1 = 6'b000000;
        u_if.data2 = 24'h090807; u_if.tw2 = 6'b000001; u_if.dp2 = 6'b100000;

        // 1) reset then single requester 0
        tick(); tick();
        check_out("reset", 3'b000, 1'b0, 24'hFFFFFF, 6'b0, 6'b0);
        rst = 1'b0;
        u_if.req = 3'b001;
        tick();
        check_out("t1_load", 3'b001, 1'b0, 24'hFFFFFF, 6'b0, 6'b0);
        tick();
        check_out("t1_frame", 3'b001, 1'b1, 24'h123456, 6'b000000, 6'b000100);
        $display("txn 1: owner 0 granted, frame %h", u_if.data_sd);

        // 2) requester 1 arrives after 3 HOLD cycles, waits for hold saturation
        tick();
        check("t2_single_pulse", 32'(u_if.valid_sd), 32'd0);
        tick();
        u_if.req = 3'b011;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_wait_gnt", 32'(u_if.gnt), 32'(3'b001));
        end
        tick();
        check_out("t2_load", 3'b010, 1'b0, 24'h123456, 6'b000000, 6'b000100);
        tick();
        check_out("t2_frame", 3'b010, 1'b1, 24'h987654, 6'b110000, 6'b000000);
        $display("txn 2: preempted to owner 1, frame %h", u_if.data_sd);

        // 3) owner 1 releases while pulsing upd; upd dropped, owner 0 loaded
        u_if.data0 = 24'h112233; u_if.tw0 = 6'b000011;
        u_if.data1 = 24'h555555;
        u_if.req = 3'b001; u_if.upd = 3'b010;
        tick();
        u_if.upd = 3'b000;
        check_out("t3_load", 3'b001, 1'b0, 24'h987654, 6'b110000, 6'b000000);
        tick();
        check_out("t3_frame", 3'b001, 1'b1, 24'h112233, 6'b000011, 6'b000100);
        $display("txn 3: handover to owner 0, frame %h", u_if.data_sd);

        // 5) owner 0 releases, nobody left: blank once
        u_if.req = 3'b000;
        tick();
        check_out("t5_blank", 3'b000, 1'b1, 24'hFFFFFF, 6'b0, 6'b0);
        tick();
        check_out("t5_idle", 3'b000, 1'b0, 24'hFFFFFF, 6'b0, 6'b0);
        $display("txn 5: display blanked");

        // 4) owner 2 alone: periodic re-issue, then upd restarts the period
        u_if.req = 3'b100;
        tick();
        check("t4_gnt", 32'(u_if.gnt), 32'(3'b100));
        tick();
        check_out("t4_frame", 3'b100, 1'b1, 24'h090807, 6'b000001, 6'b100000);
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("t4_refresh%0d", i), 32'(u_if.valid_sd), 32'((i == 16) || (i == 32)));
        end
        // ten quiet cycles; a non-owner upd in the first must be ignored
        u_if.upd = 3'b001;
        for (int i = 1; i <= 10; i++) begin
            tick();
            u_if.upd = 3'b000;
            check($sformatf("t4_quiet%0d", i), 32'(u_if.valid_sd), 32'd0);
        end
        u_if.data2 = 24'h010203;
        u_if.upd = 3'b100;
        tick();
        u_if.upd = 3'b000;
        check_out("t4_upd", 3'b100, 1'b1, 24'h010203, 6'b000001, 6'b100000);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("t4_after_upd%0d", i), 32'(u_if.valid_sd), 32'(i == 16));
        end
        $display("txn 4: owner 2 refresh cadence done");

        // 6) reset mid-HOLD with owner update pulsing
        tick();
        rst = 1'b1; u_if.upd = 3'b100;
        tick();
        check_out("t6_reset", 3'b000, 1'b0, 24'hFFFFFF, 6'b0, 6'b0);
        rst = 1'b0; u_if.upd = 3'b000; u_if.req = 3'b000;
        tick();
        check_out("t6_idle", 3'b000, 1'b0, 24'hFFFFFF, 6'b0, 6'b0);
        $display("txn 6: reset mid-hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
